// File: rtl/sipo_pkg.sv
// Shared constants and helpers for the serial-in/parallel-out deserializer.
// Bit-order encoding and counter sizing live here so every file agrees.
package sipo_pkg;

  localparam int BIT_ORDER_LSB = 0;
  localparam int BIT_ORDER_MSB = 1;

  localparam int WIDTH_MIN = 2;
  localparam int WIDTH_MAX = 64;

  typedef enum logic {
    ORDER_LSB = 1'b0,
    ORDER_MSB = 1'b1
  } bit_order_e;

  // Bits needed to count 0..w-1; never below one bit.
  function automatic int cnt_w(input int w);
    if (w < 2) begin
      return 1;
    end
    return $clog2(w);
  endfunction

endpackage

// File: rtl/sipo_out_reg.sv
// Output holding register for the deserializer: parallel word,
// valid/ready handshake and sticky overrun flag.
module sipo_out_reg
  import sipo_pkg::*;
#(
  parameter int WIDTH = 8
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             clear,
  input  logic             load,
  input  logic [WIDTH-1:0] word,
  input  logic             po_ready,
  output logic [WIDTH-1:0] po,
  output logic             po_valid,
  output logic             overrun
);

  logic [WIDTH-1:0] po_q;
  logic [WIDTH-1:0] po_d;
  logic             po_valid_q;
  logic             po_valid_d;
  logic             overrun_q;
  logic             overrun_d;
  logic             hs;
  logic             room;

  assign hs   = po_valid_q & po_ready;
  assign room = ~po_valid_q | hs;

  always_comb begin
    po_d       = po_q;
    po_valid_d = po_valid_q;
    overrun_d  = overrun_q;
    if (clear) begin
      po_valid_d = 1'b0;
      overrun_d  = 1'b0;
    end else begin
      if (hs) begin
        po_valid_d = 1'b0;
      end
      // A finished word either takes the slot or is dropped.
      if (load) begin
        if (room) begin
          po_d       = word;
          po_valid_d = 1'b1;
        end else begin
          overrun_d  = 1'b1;
        end
      end
    end
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      po_q       <= '0;
      po_valid_q <= 1'b0;
      overrun_q  <= 1'b0;
    end else begin
      po_q       <= po_d;
      po_valid_q <= po_valid_d;
      overrun_q  <= overrun_d;
    end
  end

  assign po       = po_q;
  assign po_valid = po_valid_q;
  assign overrun  = overrun_q;

endmodule

// File: rtl/sipo_deser.sv
// Serial-in/parallel-out deserializer with gapped input, selectable
// bit order and a single-entry output register with overrun detection.
module sipo_deser
  import sipo_pkg::*;
#(
  parameter int WIDTH     = 8,
  parameter int MSB_FIRST = 1
) (
  input  logic                      clk,
  input  logic                      rst,
  input  logic                      clear,
  input  logic                      si,
  input  logic                      si_valid,
  output logic [WIDTH-1:0]          po,
  output logic                      po_valid,
  input  logic                      po_ready,
  output logic                      overrun,
  output logic [cnt_w(WIDTH)-1:0]   bit_cnt
);

  localparam int CW = cnt_w(WIDTH);
  localparam logic [CW-1:0] LAST = CW'(WIDTH - 1);

  // Only WIDTH-1 earlier bits are stored; the final bit joins
  // combinationally so the word is whole on its own edge.
  logic [WIDTH-2:0] sr_q;
  logic [WIDTH-2:0] sr_d;
  logic [WIDTH-2:0] sr_nxt;
  logic [CW-1:0]    bit_cnt_q;
  logic [CW-1:0]    bit_cnt_d;
  logic [WIDTH-1:0] word;
  logic             accept;
  logic             word_done;

  generate
    if (MSB_FIRST == BIT_ORDER_MSB) begin : g_msb
      assign word   = {sr_q, si};
      assign sr_nxt = word[WIDTH-2:0];
    end else begin : g_lsb
      assign word   = {si, sr_q};
      assign sr_nxt = word[WIDTH-1:1];
    end
  endgenerate

  assign accept    = si_valid & ~clear;
  assign word_done = accept & (bit_cnt_q == LAST);

  always_comb begin
    sr_d      = sr_q;
    bit_cnt_d = bit_cnt_q;
    if (clear) begin
      sr_d      = '0;
      bit_cnt_d = '0;
    end else if (accept) begin
      sr_d = sr_nxt;
      if (bit_cnt_q == LAST) begin
        bit_cnt_d = '0;
      end else begin
        bit_cnt_d = bit_cnt_q + CW'(1);
      end
    end
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      sr_q      <= '0;
      bit_cnt_q <= '0;
    end else begin
      sr_q      <= sr_d;
      bit_cnt_q <= bit_cnt_d;
    end
  end

  assign bit_cnt = bit_cnt_q;

  sipo_out_reg #(
    .WIDTH (WIDTH)
  ) u_out (
    .clk      (clk),
    .rst      (rst),
    .clear    (clear),
    .load     (word_done),
    .word     (word),
    .po_ready (po_ready),
    .po       (po),
    .po_valid (po_valid),
    .overrun  (overrun)
  );

endmodule

// File: tb/tb_sipo_deser.sv
// Directed bench for sipo_deser, WIDTH=4, both bit orders
// driven from the same serial stream.
module tb_sipo_deser;

  logic       clk = 1'b0;
  logic       rst;
  logic       clear;
  logic       si;
  logic       si_valid;
  logic       po_ready;

  logic [3:0] po_m;
  logic       pv_m;
  logic       ov_m;
  logic [1:0] cnt_m;

  logic [3:0] po_l;
  logic       pv_l;
  logic       ov_l;
  logic [1:0] cnt_l;

  int passes = 0;
  int total  = 0;

  always #5 clk = ~clk;

  sipo_deser #(.WIDTH(4), .MSB_FIRST(1)) dut_m (
    .clk      (clk),
    .rst      (rst),
    .clear    (clear),
    .si       (si),
    .si_valid (si_valid),
    .po       (po_m),
    .po_valid (pv_m),
    .po_ready (po_ready),
    .overrun  (ov_m),
    .bit_cnt  (cnt_m)
  );

  sipo_deser #(.WIDTH(4), .MSB_FIRST(0)) dut_l (
    .clk      (clk),
    .rst      (rst),
    .clear    (clear),
    .si       (si),
    .si_valid (si_valid),
    .po       (po_l),
    .po_valid (pv_l),
    .po_ready (po_ready),
    .overrun  (ov_l),
    .bit_cnt  (cnt_l)
  );

  task automatic chk(input string tag,
                     input logic [63:0] obs,
                     input logic [63:0] exp);
    total++;
    assert (obs === exp) passes++;
    else $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
  endtask

  // Drive one cycle at the falling edge, sample 1 after rising edge.
  task automatic step(input logic b, input logic v, input logic rdy);
    @(negedge clk);
    si       = b;
    si_valid = v;
    po_ready = rdy;
    @(posedge clk);
    #1;
  endtask

  // Bits go out w[3] first.
  task automatic send(input logic [3:0] w, input logic rdy);
    for (int i = 3; i >= 0; i--) begin
      step(w[i], 1'b1, rdy);
    end
  endtask

  initial begin
    rst      = 1'b1;
    clear    = 1'b0;
    si       = 1'b0;
    si_valid = 1'b0;
    po_ready = 1'b0;
    repeat (2) @(posedge clk);
    #1;
    chk("rst_po",      po_m,  4'h0);
    chk("rst_valid",   pv_m,  1'b0);
    chk("rst_overrun", ov_m,  1'b0);
    chk("rst_cnt",     cnt_m, 2'd0);
    @(negedge clk);
    rst = 1'b0;

    // 1,0,1,1 in both orders
    send(4'b1011, 1'b0);
    chk("msb_po",    po_m,  4'b1011);
    chk("msb_valid", pv_m,  1'b1);
    chk("msb_cnt",   cnt_m, 2'd0);
    chk("lsb_po",    po_l,  4'b1101);
    chk("lsb_valid", pv_l,  1'b1);
    step(1'b0, 1'b0, 1'b1);
    chk("drain1_valid", pv_m, 1'b0);
    chk("drain1_po",    po_m, 4'b1011);

    // gapped frame 1,1,<3 idle>,0,0
    step(1'b1, 1'b1, 1'b0);
    step(1'b1, 1'b1, 1'b0);
    chk("gap_cnt0", cnt_m, 2'd2);
    for (int g = 0; g < 3; g++) begin
      step(1'b0, 1'b0, 1'b0);
      chk("gap_cnt_hold", cnt_m, 2'd2);
    end
    chk("gap_novalid", pv_m, 1'b0);
    step(1'b0, 1'b1, 1'b0);
    step(1'b0, 1'b1, 1'b0);
    chk("gap_po",    po_m, 4'b1100);
    chk("gap_valid", pv_m, 1'b1);
    step(1'b0, 1'b0, 1'b1);
    chk("drain2_valid", pv_m, 1'b0);

    // stalled consumer: second word lost
    send(4'b1010, 1'b0);
    chk("ovr_first_po", po_m, 4'b1010);
    chk("ovr_first_ov", ov_m, 1'b0);
    send(4'b0110, 1'b0);
    chk("ovr_po_kept", po_m, 4'b1010);
    chk("ovr_valid",   pv_m, 1'b1);
    chk("ovr_set",     ov_m, 1'b1);
    step(1'b0, 1'b0, 1'b0);
    chk("ovr_sticky",  ov_m, 1'b1);

    // clear with si_valid high: bit must be ignored
    @(negedge clk);
    clear    = 1'b1;
    si       = 1'b1;
    si_valid = 1'b1;
    @(posedge clk);
    #1;
    chk("clr_ov",    ov_m,  1'b0);
    chk("clr_valid", pv_m,  1'b0);
    chk("clr_cnt",   cnt_m, 2'd0);
    chk("clr_po",    po_m,  4'b1010);
    @(negedge clk);
    clear    = 1'b0;
    si_valid = 1'b0;

    // always-ready consumer, back-to-back words
    send(4'b0001, 1'b1);
    chk("b2b_w1_po",    po_m, 4'b0001);
    chk("b2b_w1_valid", pv_m, 1'b1);
    step(1'b1, 1'b1, 1'b1);
    chk("b2b_hs_clear", pv_m, 1'b0);
    step(1'b0, 1'b1, 1'b1);
    step(1'b0, 1'b1, 1'b1);
    step(1'b0, 1'b1, 1'b1);
    chk("b2b_w2_po",    po_m, 4'b1000);
    chk("b2b_w2_valid", pv_m, 1'b1);
    chk("b2b_ov",       ov_m, 1'b0);

    // handshake coincident with completion of the next word
    step(1'b0, 1'b1, 1'b0);
    step(1'b1, 1'b1, 1'b0);
    step(1'b0, 1'b1, 1'b0);
    chk("same_hold_po", po_m, 4'b1000);
    step(1'b1, 1'b1, 1'b1);
    chk("same_po",    po_m, 4'b0101);
    chk("same_valid", pv_m, 1'b1);
    chk("same_ov",    ov_m, 1'b0);
    step(1'b0, 1'b0, 1'b1);
    chk("drain3_valid", pv_m, 1'b0);

    // reset mid-frame
    step(1'b1, 1'b1, 1'b0);
    step(1'b1, 1'b1, 1'b0);
    chk("mid_cnt", cnt_m, 2'd2);
    @(negedge clk);
    si_valid = 1'b0;
    rst      = 1'b1;
    #1;
    chk("mrst_po",    po_m,  4'h0);
    chk("mrst_valid", pv_m,  1'b0);
    chk("mrst_ov",    ov_m,  1'b0);
    chk("mrst_cnt",   cnt_m, 2'd0);
    @(negedge clk);
    rst = 1'b0;
    step(1'b0, 1'b1, 1'b0);
    chk("post_cnt", cnt_m, 2'd1);
    step(1'b1, 1'b1, 1'b0);
    step(1'b1, 1'b1, 1'b0);
    step(1'b1, 1'b1, 1'b0);
    chk("post_po",    po_m, 4'b0111);
    chk("post_valid", pv_m, 1'b1);
    chk("post_lsb",   po_l, 4'b1110);

    $display("%0d/%0d checks passed", passes, total);
    $finish;
  end

endmodule
